sap_control_sequencer: RTL

- Upstream control stage for the 8-bit bus/accumulator/ALU datapath (A register, B register, adder/subtractor with CF/ZF).
- Holds the program counter (PC), memory address register (MAR) and instruction register (IR).
- Runs a 6-state T-cycle sequencer; each state emits one control word that steers the shared bus and the register load/enable lines of the datapath.
- Fetches instructions from an external 16x8 RAM whose read data the top level places on the bus.

---
 rtl/sap_control_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: PC, MAR and IR plus the six-state T-cycle control-word decode.
// Optional macro SAP_JUMP_EN adds JMP/JC/JZ; when it is undefined those opcodes execute as NOP.
module sap_control_sequencer #(
  parameter logic [3:0] PC_RESET = 4'h0,
  parameter int         T_LAST   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  output logic [3:0] mem_addr,
  output logic       mem_ce,
  output logic       nLa,
  output logic       Ea,
  output logic       nLb,
  output logic       Eb,
  output logic       Eu,
  output logic       sub,
  output logic       out_load,
  input  logic       cf,
  input  logic       zf,
  output logic       halted,
  output logic [2:0] tstate
);

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [2:0] T_END  = 3'(T_LAST);

  tstate_t    state_q;
  tstate_t    state_next;
  logic [3:0] pc_q;
  logic [3:0] mar_q;
  logic [7:0] ir_q;
  logic       halted_q;

  logic [3:0] opcode;
  logic       active;
  logic       jump_taken;

  // Raw control word before run/halt gating.
  logic       drive_d;
  logic [7:0] drive_val_d;
  logic       mem_ce_d;
  logic       nla_d;
  logic       nlb_d;
  logic       ea_d;
  logic       eu_d;
  logic       sub_d;
  logic       out_load_d;

  assign opcode = ir_q[7:4];
  assign active = run & ~halted_q;

`ifdef SAP_JUMP_EN
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = cf;
      OP_JZ:   jump_taken = zf;
      default: jump_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign jump_taken   = 1'b0;
  assign unused_flags = cf ^ zf;
`endif

  // HLT parks the sequencer in T4 until reset.
  always_comb begin
    if (state_q == T4 && opcode == OP_HLT) begin
      state_next = T4;
    end else if (state_q == tstate_t'(T_END)) begin
      state_next = T1;
    end else begin
      state_next = tstate_t'(state_q + 3'd1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
    drive_d     = 1'b0;
    drive_val_d = 8'h00;
    mem_ce_d    = 1'b0;
    nla_d       = 1'b1;
    nlb_d       = 1'b1;
    ea_d        = 1'b0;
    eu_d        = 1'b0;
    sub_d       = 1'b0;
    out_load_d  = 1'b0;
    case (state_q)
      T1: begin
        drive_d     = 1'b1;
        drive_val_d = {4'h0, pc_q};
      end
      T3: mem_ce_d = 1'b1;
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            drive_d     = 1'b1;
            drive_val_d = {4'h0, ir_q[3:0]};
          end
          OP_OUT: begin
            ea_d       = 1'b1;
            out_load_d = 1'b1;
          end
          default: begin
            if (jump_taken) begin
              drive_d     = 1'b1;
              drive_val_d = {4'h0, ir_q[3:0]};
            end
          end
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            mem_ce_d = 1'b1;
            nla_d    = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            mem_ce_d = 1'b1;
            nlb_d    = 1'b0;
          end
          default: ;
        endcase
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          eu_d  = 1'b1;
          nla_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Subtract is set from T4 so the ALU has settled before the T6 write-back.
    if (opcode == OP_SUB && (state_q == T4 || state_q == T5 || state_q == T6)) begin
      sub_d = 1'b1;
    end
  end

  assign bus_drive = active & drive_d;
  assign bus_out   = (active & drive_d) ? drive_val_d : 8'h00;
  assign mem_ce    = active & mem_ce_d;
  assign nLa       = nla_d | ~active;
  assign nLb       = nlb_d | ~active;
  assign Ea        = active & ea_d;
  assign Eb        = 1'b0;
  assign Eu        = active & eu_d;
  assign sub       = active & sub_d;
  assign out_load  = active & out_load_d;
  assign mem_addr  = mar_q;
  assign halted    = halted_q;
  assign tstate    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= T1;
      pc_q     <= PC_RESET;
      mar_q    <= 4'h0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else if (active) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      state_q <= state_next;
      case (state_q)
        T1: mar_q <= bus_in[3:0];
        T2: pc_q  <= pc_q + 4'd1;
        T3: ir_q  <= bus_in;
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            mar_q <= bus_in[3:0];
          end
          if (jump_taken) begin
            pc_q <= bus_in[3:0];
          end
          if (opcode == OP_HLT) begin
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
